// File: rtl/clk_phase_gen_pkg.sv
// ============================================================================
// clk_phase_gen_pkg : shared types, phase function and default channel map
// Rev 1.0
// ============================================================================
`default_nettype none

package clk_phase_gen_pkg;

  typedef enum logic {
    CNT_GATED = 1'b0,
    CNT_FREE  = 1'b1
  } cnt_sel_e;

  function automatic int unsigned phase_w(input int unsigned div);
    return $clog2(div);
  endfunction

  // Standard map: ch0 processor, ch1 regfile, ch2 imem, ch3 dmem
  localparam int unsigned                        STD_DIV      = 4;
  localparam int unsigned                        STD_NCH      = 4;
  localparam int unsigned                        STD_PW       = phase_w(STD_DIV);
  localparam logic [STD_NCH*STD_PW-1:0]          STD_CH_PHASE = {2'd3, 2'd1, 2'd2, 2'd0};
  localparam logic [STD_NCH-1:0]                 STD_CH_FREE  = 4'b1100;

  // High for the second half of the period seen from the channel's offset
  function automatic logic phase_hi(input int unsigned c, input int unsigned off,
                                    input int unsigned div);
    return ((c + div - off) % div) >= (div / 2);
  endfunction

endpackage

`default_nettype wire

// File: rtl/clk_phase_ch.sv
// ============================================================================
// clk_phase_ch : one registered divided-clock channel with rising-edge tick
// Rev 1.0
// ============================================================================
`default_nettype none

module clk_phase_ch
  import clk_phase_gen_pkg::*;
#(
  parameter int DIV = 4,
  parameter int PW  = $clog2(DIV)
) (
  input  logic          clk,
  input  logic          rst,
  input  cnt_sel_e      i_sel,
  input  logic [PW-1:0] i_off,
  input  logic [PW-1:0] i_gcnt_nxt,
  input  logic [PW-1:0] i_fcnt_nxt,
  output logic          o_clk,
  output logic          o_tick
);

  logic [PW-1:0] w_cnt_nxt;
  logic          w_clk_nxt;
  logic          r_clk;
  logic          r_tick;

  assign w_cnt_nxt = (i_sel == CNT_FREE) ? i_fcnt_nxt : i_gcnt_nxt;
  assign w_clk_nxt = phase_hi(32'(w_cnt_nxt), 32'(i_off), $unsigned(DIV));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk  <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_clk  <= w_clk_nxt;
      r_tick <= w_clk_nxt & ~r_clk;
    end
  end

  assign o_clk  = r_clk;
  assign o_tick = r_tick;

endmodule

`default_nettype wire

// File: rtl/clk_phase_gen.sv
// ============================================================================
// clk_phase_gen : gated/free phase counters, stall hold, processor cycle count
// Rev 1.0
// ============================================================================
`default_nettype none

module clk_phase_gen
  import clk_phase_gen_pkg::*;
#(
  parameter int                  DIV      = 4,
  parameter int                  NCH      = 4,
  parameter int                  PW       = $clog2(DIV),
  parameter logic [NCH*PW-1:0]   CH_PHASE = '0,
  parameter logic [NCH-1:0]      CH_FREE  = '0,
  parameter int                  CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_stall,
  output logic [NCH-1:0]   o_ch_clk,
  output logic [NCH-1:0]   o_ch_tick,
  output logic [PW-1:0]    o_proc_phase,
  output logic             o_stalled,
  output logic [CNT_W-1:0] o_cycle_count
);

  localparam logic [PW-1:0] c_last    = PW'(DIV - 1);
  localparam logic [PW-1:0] c_half_m1 = PW'(DIV / 2 - 1);
  localparam logic [PW-1:0] c_half    = PW'(DIV / 2);

  logic [PW-1:0]    r_gcnt;
  logic [PW-1:0]    r_fcnt;
  logic             r_stalled;
  logic [CNT_W-1:0] r_cycle_count;

  logic             w_gcnt_hold;
  logic [PW-1:0]    w_gcnt_inc;
  logic [PW-1:0]    w_gcnt_nxt;
  logic [PW-1:0]    w_fcnt_nxt;
  logic             w_proc_rise;

  // Stall only bites at gcnt == 0, so a running high phase always completes
  assign w_gcnt_hold = (r_gcnt == '0) && i_stall;
  assign w_gcnt_inc  = (r_gcnt == c_last) ? '0 : r_gcnt + PW'(1);
  assign w_gcnt_nxt  = w_gcnt_hold ? r_gcnt : w_gcnt_inc;
  assign w_fcnt_nxt  = (r_fcnt == c_last) ? '0 : r_fcnt + PW'(1);
  assign w_proc_rise = (r_gcnt == c_half_m1) && (w_gcnt_nxt == c_half);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_gcnt        <= '0;
      r_fcnt        <= '0;
      r_stalled     <= 1'b0;
      r_cycle_count <= '0;
    end else begin
      r_gcnt    <= w_gcnt_nxt;
      r_fcnt    <= w_fcnt_nxt;
      r_stalled <= (w_gcnt_nxt == '0) && (r_gcnt == '0) && i_stall;
      if (w_proc_rise) begin
        r_cycle_count <= r_cycle_count + CNT_W'(1);
      end
    end
  end

  generate
    for (genvar i = 0; i < NCH; i++) begin : g_ch
      clk_phase_ch #(
        .DIV (DIV),
        .PW  (PW)
      ) u_ch (
        .clk        (clk),
        .rst        (rst),
        .i_sel      (CH_FREE[i] ? CNT_FREE : CNT_GATED),
        .i_off      (CH_PHASE[i*PW +: PW]),
        .i_gcnt_nxt (w_gcnt_nxt),
        .i_fcnt_nxt (w_fcnt_nxt),
        .o_clk      (o_ch_clk[i]),
        .o_tick     (o_ch_tick[i])
      );
    end
  endgenerate

  assign o_proc_phase  = r_gcnt;
  assign o_stalled     = r_stalled;
  assign o_cycle_count = r_cycle_count;

endmodule

`default_nettype wire

// File: tb/tb_clk_phase_gen.sv
// ============================================================================
// tb_clk_phase_gen : directed checks of phases, stall hold, reset and wrap
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_clk_phase_gen;

  // ch0 gated off 0, ch1 gated off 2, ch2 free off 0, ch3 free off 1
  localparam int              DIV      = 4;
  localparam int              NCH      = 4;
  localparam int              PW       = 2;
  localparam logic [7:0]      CH_PHASE = {2'd1, 2'd0, 2'd2, 2'd0};
  localparam logic [3:0]      CH_FREE  = 4'b1100;
  localparam int              CNT_W    = 4;

  logic             clk;
  logic             rst;
  logic             i_stall;
  logic [NCH-1:0]   o_ch_clk;
  logic [NCH-1:0]   o_ch_tick;
  logic [PW-1:0]    o_proc_phase;
  logic             o_stalled;
  logic [CNT_W-1:0] o_cycle_count;

  int n_tests;
  int n_fail;

  // Hand-derived levels: bit0 = ch0/ch2 (off 0), bit1 = ch1 (off 2) / ch3 (off 1)
  logic [1:0] g_tab [4];
  logic [1:0] f_tab [4];
  int         ef;
  logic [3:0] prev_ch;

  clk_phase_gen #(
    .DIV      (DIV),
    .NCH      (NCH),
    .PW       (PW),
    .CH_PHASE (CH_PHASE),
    .CH_FREE  (CH_FREE),
    .CNT_W    (CNT_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_stall       (i_stall),
    .o_ch_clk      (o_ch_clk),
    .o_ch_tick     (o_ch_tick),
    .o_proc_phase  (o_proc_phase),
    .o_stalled     (o_stalled),
    .o_cycle_count (o_cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".ch_clk"},  32'(o_ch_clk), 32'd0);
    chk({tag, ".ch_tick"}, 32'(o_ch_tick), 32'd0);
    chk({tag, ".phase"},   32'(o_proc_phase), 32'd0);
    chk({tag, ".stalled"}, 32'(o_stalled), 32'd0);
    chk({tag, ".count"},   32'(o_cycle_count), 32'd0);
  endtask

  // One edge with the given stall; checks against hand-listed gcnt/stalled/count
  task automatic cyc(input string tag, input logic stall, input int eg,
                     input logic est, input int ecc);
    logic [3:0] ech;
    i_stall = stall;
    @(posedge clk);
    @(negedge clk);
    ef  = (ef + 1) % DIV;
    ech = {f_tab[ef], g_tab[eg]};
    chk({tag, ".phase"},   32'(o_proc_phase), 32'(eg));
    chk({tag, ".stalled"}, 32'(o_stalled), 32'(est));
    chk({tag, ".count"},   32'(o_cycle_count), 32'(ecc));
    chk({tag, ".ch_clk"},  32'(o_ch_clk), 32'(ech));
    chk({tag, ".ch_tick"}, 32'(o_ch_tick), 32'(ech & ~prev_ch));
    prev_ch = ech;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    g_tab   = '{2'b10, 2'b10, 2'b01, 2'b01};
    f_tab   = '{2'b10, 2'b00, 2'b01, 2'b11};
    ef      = 0;
    prev_ch = 4'b0000;
    rst     = 1'b1;
    i_stall = 1'b0;

    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // Free-running: 12 edges, processor rises at edges 2, 6, 10
    for (int k = 1; k <= 12; k++) begin
      cyc("run", 1'b0, k % 4, 1'b0, (k + 2) / 4);
    end

    cyc("pre_stall", 1'b0, 1, 1'b0, 3);
    cyc("pre_stall", 1'b0, 2, 1'b0, 4);
    // Stall raised at gcnt = 2: finishes 3, 0 then holds
    cyc("stall_a", 1'b1, 3, 1'b0, 4);
    cyc("stall_b", 1'b1, 0, 1'b0, 4);
    for (int k = 0; k < 6; k++) begin
      cyc("stall_hold", 1'b1, 0, 1'b1, 4);
    end
    // Release coincides with gcnt == 0: increments on this edge
    cyc("release", 1'b0, 1, 1'b0, 4);
    cyc("post_rel", 1'b0, 2, 1'b0, 5);
    cyc("post_rel", 1'b0, 3, 1'b0, 5);
    cyc("post_rel", 1'b0, 0, 1'b0, 5);

    // One-cycle stall pulse while gcnt = 1 has no effect
    cyc("pulse_pre", 1'b0, 1, 1'b0, 5);
    cyc("pulse",     1'b1, 2, 1'b0, 6);
    cyc("pulse_post", 1'b0, 3, 1'b0, 6);

    // Asynchronous reset between edges while ch0 is high at gcnt = 3
    chk("mid_pre.ch0", 32'(o_ch_clk[0]), 32'd1);
    #2 rst = 1'b1;
    #1 chk_zero("mid_reset");
    @(negedge clk);
    chk_zero("mid_reset_hold");
    rst     = 1'b0;
    ef      = 0;
    prev_ch = 4'b0000;
    cyc("restart", 1'b0, 1, 1'b0, 0);

    // Counter wraps 15 -> 0 after 16 processor rises
    for (int k = 2; k <= 64; k++) begin
      cyc("wrap", 1'b0, k % 4, 1'b0, ((k + 2) / 4) % 16);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
